// File: rtl/mult8_rev_ctrl.sv
// Reversible 8x8 multiplier and the controller that time-shares it between a
// forward (a*b) channel and a reverse (p, a -> b) channel with a valid/ready response port.

module mult8_rev (
    input  logic        dir,
    input  logic [7:0]  f_a,
    input  logic [7:0]  f_b,
    input  logic [15:0] r_p,
    input  logic [7:0]  r_b0_r_b,
    input  logic [47:0] r_b27,
    input  logic        r_x_c0,
    output logic [15:0] f_p,
    output logic [7:0]  f_b0_r_b,
    output logic [47:0] f_b27_r_b,
    output logic        f_x_c0_b,
    output logic [7:0]  r_a,
    output logic [7:0]  r_b
);
    logic [7:0]  a_rev;
    logic [8:0]  rem;
    logic [15:0] quo;

    // Forward: product plus ancilla lines that must come back clean (A copied into b0).
    always_comb begin
        f_p       = dir ? 16'h0000 : 16'(f_a) * 16'(f_b);
        f_b0_r_b  = dir ? 8'h00 : (f_a ^ r_b0_r_b);
        f_b27_r_b = dir ? 48'h0 : r_b27;
        f_x_c0_b  = dir ? 1'b0 : r_x_c0;
    end

    // Reverse: recover A from the ancilla and B = P / A; no 8-bit preimage yields 0.
    always_comb begin
        a_rev = r_b0_r_b ^ f_a;
        rem   = 9'h000;
        quo   = 16'h0000;
        for (int i = 15; i >= 0; i--) begin
            rem = {rem[7:0], r_p[i]};
            if (rem >= {1'b0, a_rev}) begin
                rem    = rem - {1'b0, a_rev};
                quo[i] = 1'b1;
            end
        end
        r_a = dir ? a_rev : 8'h00;
        r_b = (dir && a_rev != 8'h00 && quo[15:8] == 8'h00) ? quo[7:0] : 8'h00;
    end
endmodule

module mult8_rev_ctrl #(
    parameter int unsigned DIR_SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fwd_valid,
    output logic        fwd_ready,
    input  logic [7:0]  fwd_a,
    input  logic [7:0]  fwd_b,
    input  logic        rev_valid,
    output logic        rev_ready,
    input  logic [15:0] rev_p,
    input  logic [7:0]  rev_a,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_dir,
    output logic [15:0] rsp_data,
    output logic [7:0]  rsp_anc,
    output logic        rsp_err,
    output logic [7:0]  fwd_done,
    output logic [7:0]  rev_done,
    output logic [7:0]  err_count
);
    localparam int unsigned SET_W = (DIR_SETTLE > 1) ? $clog2(DIR_SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, EXEC, HOLD} state_t;

    state_t             state, state_d;
    logic               dir_q, last_grant;
    logic [7:0]         op_a, op_b;
    logic [15:0]        op_p;
    logic [SET_W-1:0]   settle_cnt;
    logic               grant_fwd, accept, acc_dir, settle_done, exec, fwd_err, rev_err;

    logic [7:0]  m_f_a, m_f_b, m_r_b0, m_f_b0, m_r_a, m_r_b;
    logic [15:0] m_r_p, m_f_p;
    logic [47:0] m_f_b27;
    logic        m_f_x_c0;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Arbitration, handshakes and next state; last_grant = 1 means reverse won last.
    always_comb begin
        state_d     = state;
        grant_fwd   = fwd_valid & (~rev_valid | last_grant);
        fwd_ready   = ~rst & (state == IDLE) & fwd_valid & grant_fwd;
        rev_ready   = ~rst & (state == IDLE) & rev_valid & ~grant_fwd;
        accept      = fwd_ready | rev_ready;
        acc_dir     = rev_ready;
        settle_done = (32'(settle_cnt) + 32'd1) >= DIR_SETTLE;
        case (state)
            IDLE:   if (accept) state_d = (acc_dir != dir_q && DIR_SETTLE > 0) ? SETTLE : EXEC;
            SETTLE: if (settle_done) state_d = EXEC;
            EXEC:   state_d = HOLD;
            HOLD:   if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Multiplier is only driven from the operand registers during EXEC.
    always_comb begin
        exec   = (state == EXEC);
        m_f_a  = (exec & ~dir_q) ? op_a : 8'h00;
        m_f_b  = (exec & ~dir_q) ? op_b : 8'h00;
        m_r_p  = (exec &  dir_q) ? op_p : 16'h0000;
        m_r_b0 = (exec &  dir_q) ? op_a : 8'h00;
    end

    mult8_rev u_mult (
        .dir       (dir_q),
        .f_a       (m_f_a),
        .f_b       (m_f_b),
        .r_p       (m_r_p),
        .r_b0_r_b  (m_r_b0),
        .r_b27     (48'h0),
        .r_x_c0    (1'b0),
        .f_p       (m_f_p),
        .f_b0_r_b  (m_f_b0),
        .f_b27_r_b (m_f_b27),
        .f_x_c0_b  (m_f_x_c0),
        .r_a       (m_r_a),
        .r_b       (m_r_b)
    );

    always_comb begin
        fwd_err = (|m_f_b27) | m_f_x_c0 | (m_f_b0 != op_a);
        rev_err = (m_r_a != op_a) | ((16'(m_r_b) * 16'(op_a)) != op_p);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q      <= 1'b0;
            last_grant <= 1'b1;
            op_a       <= 8'h00;
            op_b       <= 8'h00;
            op_p       <= 16'h0000;
            settle_cnt <= '0;
            rsp_valid  <= 1'b0;
            rsp_dir    <= 1'b0;
            rsp_data   <= 16'h0000;
            rsp_anc    <= 8'h00;
            rsp_err    <= 1'b0;
            fwd_done   <= 8'h00;
            rev_done   <= 8'h00;
            err_count  <= 8'h00;
        end else begin
            settle_cnt <= (state == SETTLE) ? settle_cnt + SET_W'(1) : '0;
            if (accept) begin
                dir_q      <= acc_dir;
                last_grant <= acc_dir;
                op_a       <= acc_dir ? rev_a : fwd_a;
                op_b       <= fwd_b;
                op_p       <= rev_p;
            end
            if (exec) begin
                rsp_valid <= 1'b1;
                rsp_dir   <= dir_q;
                rsp_data  <= dir_q ? {m_r_a, m_r_b} : m_f_p;
                rsp_anc   <= dir_q ? 8'h00 : m_f_b0;
                rsp_err   <= dir_q ? rev_err : fwd_err;
            end
            if (state == HOLD && rsp_ready) begin
                rsp_valid <= 1'b0;
                if (rsp_dir) rev_done <= rev_done + 8'd1;
                else         fwd_done <= fwd_done + 8'd1;
                if (rsp_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mult8_rev_ctrl.sv
// Randomized self-checking bench for mult8_rev_ctrl against an arithmetic job model.

module tb_mult8_rev_ctrl;
    localparam int unsigned DS = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fwd_valid = 1'b0, rev_valid = 1'b0, rsp_ready = 1'b0;
    logic [7:0]  fwd_a = 8'h00, fwd_b = 8'h00, rev_a = 8'h00;
    logic [15:0] rev_p = 16'h0000;
    logic        fwd_ready, rev_ready, rsp_valid, rsp_dir, rsp_err;
    logic [15:0] rsp_data;
    logic [7:0]  rsp_anc, fwd_done, rev_done, err_count;

    int n_chk = 0, n_fail = 0;
    logic m_dir;
    int e_fwd, e_rev, e_err;

    mult8_rev_ctrl #(.DIR_SETTLE(DS)) dut (
        .clk(clk), .rst(rst),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .rev_valid(rev_valid), .rev_ready(rev_ready), .rev_p(rev_p), .rev_a(rev_a),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dir(rsp_dir),
        .rsp_data(rsp_data), .rsp_anc(rsp_anc), .rsp_err(rsp_err),
        .fwd_done(fwd_done), .rev_done(rev_done), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected response of one job from the multiply/divide rules.
    function automatic void model(input logic d, input logic [7:0] a, input logic [7:0] b,
                                  input logic [15:0] p, output logic [15:0] xd,
                                  output logic [7:0] xa, output logic xe, output logic full);
        int unsigned q;
        if (!d) begin
            xd = 16'(int'(a) * int'(b)); xa = a; xe = 1'b0; full = 1'b1;
        end else begin
            xa = 8'h00;
            if (a == 8'h00) begin
                xe = (p != 16'h0000); full = (p == 16'h0000); xd = 16'h0000;
            end else begin
                q = int'(p) / int'(a);
                if ((int'(p) % int'(a)) == 0 && q < 256) begin
                    xe = 1'b0; full = 1'b1; xd = {a, 8'(q)};
                end else begin
                    xe = 1'b1; full = 1'b0; xd = {a, 8'h00};
                end
            end
        end
    endfunction

    task automatic model_reset();
        m_dir = 1'b0; e_fwd = 0; e_rev = 0; e_err = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; fwd_valid = 1'b0; rev_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_counters(input string tag);
        n_chk++;
        if (fwd_done !== 8'(e_fwd) || rev_done !== 8'(e_rev) || err_count !== 8'(e_err)) begin
            n_fail++;
            $display("FAIL %s counters: got fwd=%0d rev=%0d err=%0d want fwd=%0d rev=%0d err=%0d",
                     tag, fwd_done, rev_done, err_count, e_fwd, e_rev, e_err);
        end
    endtask

    // One complete job: request, latency, response fields, optional backpressure, counters.
    task automatic run_job(input logic d, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] p, input int hold, input string tag);
        logic [15:0] xd; logic [7:0] xa; logic xe, full;
        int lat, exp_lat; bit got;
        model(d, a, b, p, xd, xa, xe, full);
        exp_lat = (d != m_dir && DS > 0) ? 2 + DS : 2;
        @(negedge clk);
        rsp_ready = (hold == 0);
        if (d) begin rev_valid = 1'b1; rev_p = p; rev_a = a; end
        else   begin fwd_valid = 1'b1; fwd_a = a; fwd_b = b; end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if ((d ? rev_ready : fwd_ready) === 1'b1) got = 1;
            else @(negedge clk);
        end
        n_chk++;
        if (!got) begin
            n_fail++; $display("FAIL %s accept: ready never rose", tag);
            fwd_valid = 1'b0; rev_valid = 1'b0; return;
        end
        @(negedge clk);
        fwd_valid = 1'b0; rev_valid = 1'b0;
        m_dir = d;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
        n_chk++;
        if (lat != exp_lat) begin
            n_fail++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
            if (rsp_valid !== 1'b1) return;
        end
        n_chk++;
        if (rsp_dir !== d || rsp_err !== xe || rsp_anc !== xa ||
            (full ? (rsp_data !== xd) : (rsp_data[15:8] !== xd[15:8]))) begin
            n_fail++;
            $display("FAIL %s response: got dir=%0b data=%h anc=%h err=%0b want dir=%0b data=%h anc=%h err=%0b full=%0b",
                     tag, rsp_dir, rsp_data, rsp_anc, rsp_err, d, xd, xa, xe, full);
        end
        if (hold > 0) begin
            fwd_valid = 1'b1; rev_valid = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk); #1;
                n_chk++;
                if (rsp_valid !== 1'b1 || fwd_ready !== 1'b0 || rev_ready !== 1'b0 ||
                    rsp_err !== xe || (full && rsp_data !== xd)) begin
                    n_fail++;
                    $display("FAIL %s hold: valid=%0b fr=%0b rr=%0b data=%h err=%0b want valid=1 ready=0 data=%h err=%0b",
                             tag, rsp_valid, fwd_ready, rev_ready, rsp_data, rsp_err, xd, xe);
                end
                check_counters({tag, "_hold"});
            end
            fwd_valid = 1'b0; rev_valid = 1'b0; rsp_ready = 1'b1;
        end
        @(negedge clk);
        if (d) e_rev = (e_rev + 1) % 256; else e_fwd = (e_fwd + 1) % 256;
        if (xe && e_err < 255) e_err++;
        n_chk++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s rsp_drop: rsp_valid=%0b want 0", tag, rsp_valid);
        end
        check_counters(tag);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; fwd_valid = 1'b1; rev_valid = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        n_chk++;
        if (fwd_ready !== 1'b0 || rev_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_dir !== 1'b0 ||
            rsp_err !== 1'b0 || rsp_data !== 16'h0 || rsp_anc !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: fr=%0b rr=%0b v=%0b dir=%0b err=%0b data=%h anc=%h want all 0",
                     fwd_ready, rev_ready, rsp_valid, rsp_dir, rsp_err, rsp_data, rsp_anc);
        end
        model_reset();
        check_counters("reset");
        fwd_valid = 1'b0; rev_valid = 1'b0; rst = 1'b0;
    endtask

    task automatic test_forward_basic();
        run_job(1'b0, 8'h12, 8'h04, 16'h0, 0, "fwd_basic");
    endtask

    task automatic test_dir_switch();
        run_job(1'b1, 8'h12, 8'h00, 16'h0048, 0, "dir_switch");
        run_job(1'b1, 8'h05, 8'h00, 16'h00C8, 0, "same_dir_rev");
        run_job(1'b0, 8'hFF, 8'hFF, 16'h0, 0, "switch_back_fwd");
    endtask

    task automatic test_round_robin();
        logic        dirs [2];
        logic [15:0] datas [2];
        int  nrsp; bit drop_f, drop_r, both;
        do_reset();
        @(negedge clk);
        rsp_ready = 1'b1;
        fwd_valid = 1'b1; fwd_a = 8'h08; fwd_b = 8'h11;
        rev_valid = 1'b1; rev_p = 16'h0088; rev_a = 8'h08;
        nrsp = 0; drop_f = 0; drop_r = 0; both = 0;
        for (int i = 0; i < 30 && nrsp < 2; i++) begin
            #1;
            if (fwd_ready === 1'b1 && rev_ready === 1'b1) both = 1;
            if (fwd_ready === 1'b1) drop_f = 1;
            if (rev_ready === 1'b1) drop_r = 1;
            if (rsp_valid === 1'b1) begin dirs[nrsp] = rsp_dir; datas[nrsp] = rsp_data; nrsp++; end
            @(negedge clk);
            if (drop_f) fwd_valid = 1'b0;
            if (drop_r) rev_valid = 1'b0;
        end
        n_chk++;
        if (nrsp != 2 || both) begin
            n_fail++; $display("FAIL rr_count: got %0d responses both_ready=%0b want 2 and 0", nrsp, both);
        end else begin
            n_chk++;
            if (dirs[0] !== 1'b0 || datas[0] !== 16'h0088) begin
                n_fail++; $display("FAIL rr_first: got dir=%0b data=%h want dir=0 data=0088", dirs[0], datas[0]);
            end
            n_chk++;
            if (dirs[1] !== 1'b1 || datas[1] !== 16'h0811) begin
                n_fail++; $display("FAIL rr_second: got dir=%0b data=%h want dir=1 data=0811", dirs[1], datas[1]);
            end
        end
        fwd_valid = 1'b0; rev_valid = 1'b0; rsp_ready = 1'b0;
        m_dir = 1'b1; e_fwd = 1; e_rev = 1;
        check_counters("rr");
    endtask

    task automatic test_errors();
        run_job(1'b1, 8'h12, 8'h00, 16'h8C40, 0, "err_rev");
        run_job(1'b1, 8'h00, 8'h00, 16'h0000, 0, "rev_zero");
        run_job(1'b1, 8'h00, 8'h00, 16'h0001, 0, "rev_zero_a_err");
        run_job(1'b1, 8'h03, 8'h00, 16'h0301, 0, "rev_too_big");
    endtask

    task automatic test_backpressure();
        run_job(1'b0, 8'h9A, 8'h37, 16'h0, 5, "bp_fwd");
        run_job(1'b1, 8'h21, 8'h00, 16'h1BEF, 5, "bp_rev_err");
    endtask

    task automatic test_reset_mid_job();
        logic d; bit got, seen;
        d = ~m_dir;
        @(negedge clk);
        if (d) begin rev_valid = 1'b1; rev_p = 16'h0100; rev_a = 8'h10; end
        else   begin fwd_valid = 1'b1; fwd_a = 8'h10; fwd_b = 8'h10; end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if ((d ? rev_ready : fwd_ready) === 1'b1) got = 1;
            else @(negedge clk);
        end
        @(negedge clk);
        rst = 1'b1; fwd_valid = 1'b1; rev_valid = 1'b0;
        @(negedge clk); #1;
        n_chk++;
        if (!got || fwd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 16'h0 ||
            rsp_anc !== 8'h0 || rsp_err !== 1'b0 || rsp_dir !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: accepted=%0b fr=%0b v=%0b data=%h anc=%h err=%0b dir=%0b want 1 and zeros",
                     got, fwd_ready, rsp_valid, rsp_data, rsp_anc, rsp_err, rsp_dir);
        end
        model_reset();
        check_counters("mid_reset");
        fwd_valid = 1'b0; rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen = 1;
        end
        n_chk++;
        if (seen) begin n_fail++; $display("FAIL mid_reset_no_rsp: response appeared after reset"); end
        run_job(1'b0, 8'h07, 8'h06, 16'h0, 0, "post_reset_fwd");
    endtask

    task automatic test_random();
        logic d; logic [7:0] a, b; logic [15:0] p;
        for (int n = 0; n < 800; n++) begin
            d = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if (d && $urandom_range(0, 3) == 0) p = 16'(int'(a) * int'(b));
            else p = 16'($urandom_range(0, 65535));
            run_job(d, a, b, p, $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_forward_basic();
        test_dir_switch();
        test_round_robin();
        test_errors();
        test_backpressure();
        test_reset_mid_job();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
